sampler_buffer_mc: RTL and testbench

// - Parametrised multi-channel successor of the sampler prefill buffer: reads a seed from seed RAM, reseeds the Trivium PRNG, then fills NUM_BUF shift-RAM buffers of DEPTH words each with PRNG output.
// - In IDLE, consumers (binomial samplers) pop each buffer through its own shift enable.
// - Adds proper valid/ready accept, busy status, a programmable RAM read latency and optional per-buffer reseeding.

---
 rtl/sampler_buffer_mc_pkg.sv | 38 +++
 rtl/shift_ram.sv | 38 +++
 rtl/sampler_buffer_mc.sv | 218 +++++++++++++++++++++
 tb/tb_sampler_buffer_mc.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sampler_buffer_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sampler_pkg
// Purpose : Shared encodings and helpers for the multi-channel sampler
//           prefill buffer (FSM state codes, seed word width, clog2).
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package sampler_pkg;

  // Seed RAM delivers the seed 32 bits at a time
  localparam int c_SEED_WORD_W = 32;

  // FSM state encoding
  localparam logic [1:0] c_ST_IDLE      = 2'd0;
  localparam logic [1:0] c_ST_LOAD_SEED = 2'd1;
  localparam logic [1:0] c_ST_RESEED    = 2'd2;
  localparam logic [1:0] c_ST_FILL      = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = c_ST_IDLE,
    LOAD_SEED = c_ST_LOAD_SEED,
    RESEED    = c_ST_RESEED,
    FILL      = c_ST_FILL
  } state_t;

  // Ceiling log2, usable in constant expressions (clog2(1) = 0)
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_ram.sv
`default_nettype none
// ============================================================================
// Module  : shift_ram
// Purpose : DEPTH-word shift register buffer. Each enabled cycle pushes di
//           in at the head; so shows the tail word, so words leave in the
//           order they were written (first-written word appears after DEPTH
//           shifts). Contents are intentionally not reset.
// Ports   : clk  in   clock
//           en   in   shift enable
//           di   in   DATA_WIDTH  word shifted in
//           so   out  DATA_WIDTH  oldest word
// Rev     : 1.0  initial release
// ============================================================================
module shift_ram #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] di,
  output logic [DATA_WIDTH-1:0] so
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      r_mem[0] <= di;
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  assign so = r_mem[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/sampler_buffer_mc.sv
`default_nettype none
// ============================================================================
// Module  : sampler_buffer_mc
// Purpose : Loads a seed from seed RAM, reseeds the PRNG, then fills NUM_BUF
//           shift-RAM buffers (DEPTH words each) with PRNG output. While IDLE
//           the consumers pop each buffer via its own bs_en bit.
// Config  : SB_PERBUF_RESEED_EN - reseed before every buffer b>0 with the
//           seed's top byte XORed with b (domain separation per buffer).
// Ports   : clk, rst_n (sync, active-low)
//           start / busy / done          control and status
//           byte_addr / byte_do          seed RAM read port (RAM_LAT latency)
//           seed / reseed / reseed_ack   PRNG seeding handshake
//           rdi_data/rdi_valid/rdi_ready PRNG word stream
//           bs_en / so                   per-buffer pop enable and outputs
// Rev     : 1.0  initial release
// ============================================================================
module sampler_buffer_mc
  import sampler_pkg::*;
#(
  parameter int NUM_BUF    = 3,
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 128,
  parameter int SEED_WORDS = 8,
  parameter int RAM_LAT    = 2,
  localparam int SEED_W    = c_SEED_WORD_W * SEED_WORDS,
  localparam int ADDR_W    = (clog2(SEED_WORDS) > 0) ? clog2(SEED_WORDS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [ADDR_W-1:0]             byte_addr,
  input  logic [31:0]                   byte_do,
  output logic [SEED_W-1:0]             seed,
  output logic                          reseed,
  input  logic                          reseed_ack,
  input  logic [DATA_WIDTH-1:0]         rdi_data,
  input  logic                          rdi_valid,
  output logic                          rdi_ready,
  input  logic [NUM_BUF-1:0]            bs_en,
  output logic [NUM_BUF*DATA_WIDTH-1:0] so
);

  localparam int c_TOTAL  = NUM_BUF * DEPTH;
  localparam int c_WCNT_W = clog2(c_TOTAL + 1);
  localparam int c_BCNT_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
  localparam int c_BUF_W  = (clog2(NUM_BUF) > 0) ? clog2(NUM_BUF) : 1;
  // Load counter spans issue cycles plus the RAM pipeline drain
  localparam int c_LD_W   = clog2(SEED_WORDS + RAM_LAT + 1);

  localparam logic [c_WCNT_W-1:0] c_WCNT_LAST     = c_WCNT_W'(c_TOTAL - 1);
  localparam logic [c_WCNT_W-1:0] c_WCNT_STOP     = c_WCNT_W'(c_TOTAL);
  localparam logic [c_BCNT_W-1:0] c_BCNT_LAST     = c_BCNT_W'(DEPTH - 1);
  localparam logic [c_LD_W-1:0]   c_LD_ISSUE_LAST = c_LD_W'(SEED_WORDS - 1);
  localparam logic [c_LD_W-1:0]   c_LD_CAP0       = c_LD_W'(RAM_LAT);
  localparam logic [c_LD_W-1:0]   c_LD_LAST       = c_LD_W'(SEED_WORDS + RAM_LAT - 1);

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_reseed;
  logic                  r_rdi_ready;
  logic [ADDR_W-1:0]     r_byte_addr;
  logic [SEED_W-1:0]     r_seed;
  logic [c_LD_W-1:0]     r_ld_cnt;
  logic [c_WCNT_W-1:0]   r_wcnt;
  logic [c_BCNT_W-1:0]   r_bcnt;
  logic [c_BUF_W-1:0]    r_buf;
`ifdef SB_PERBUF_RESEED_EN
  // Undiversified seed; r_seed carries the per-buffer variant
  logic [SEED_W-1:0]     r_seed_base;
`endif

  logic                  w_accept;
  logic                  w_last_word;
  logic                  w_last_in_buf;
  logic [c_LD_W-1:0]     w_cap_idx;
  logic [NUM_BUF-1:0]    w_shift_en;

  // r_rdi_ready is only ever high in FILL, so this is the FILL accept
  assign w_accept      = rdi_valid & r_rdi_ready;
  assign w_last_word   = (r_wcnt == c_WCNT_LAST);
  assign w_last_in_buf = (r_bcnt == c_BCNT_LAST);
  // Load cycle c captures the word issued RAM_LAT cycles earlier
  assign w_cap_idx     = r_ld_cnt - c_LD_CAP0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_reseed    <= 1'b0;
      r_rdi_ready <= 1'b0;
      r_byte_addr <= '0;
      r_seed      <= '0;
      r_ld_cnt    <= '0;
      r_wcnt      <= '0;
      r_bcnt      <= '0;
      r_buf       <= '0;
`ifdef SB_PERBUF_RESEED_EN
      r_seed_base <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= LOAD_SEED;
            r_busy      <= 1'b1;
            r_byte_addr <= '0;
            r_ld_cnt    <= '0;
            r_wcnt      <= '0;
            r_bcnt      <= '0;
            r_buf       <= '0;
          end
        end

        LOAD_SEED: begin
          // Present the next address while issue cycles remain, then park at 0
          if (r_ld_cnt < c_LD_ISSUE_LAST) begin
            r_byte_addr <= ADDR_W'(r_ld_cnt + c_LD_W'(1));
          end else begin
            r_byte_addr <= '0;
          end
          if (r_ld_cnt >= c_LD_CAP0) begin
            for (int k = 0; k < SEED_WORDS; k++) begin
              if (w_cap_idx == c_LD_W'(k)) begin
                r_seed[k*c_SEED_WORD_W +: c_SEED_WORD_W] <= byte_do;
`ifdef SB_PERBUF_RESEED_EN
                r_seed_base[k*c_SEED_WORD_W +: c_SEED_WORD_W] <= byte_do;
`endif
              end
            end
          end
          if (r_ld_cnt == c_LD_LAST) begin
            r_state  <= RESEED;
            r_reseed <= 1'b1;
          end else begin
            r_ld_cnt <= r_ld_cnt + c_LD_W'(1);
          end
        end

        RESEED: begin
          if (reseed_ack) begin
            r_reseed    <= 1'b0;
            r_rdi_ready <= 1'b1;
            r_state     <= FILL;
          end
        end

        FILL: begin
          if (w_accept) begin
            r_wcnt <= r_wcnt + c_WCNT_W'(1);
            if (w_last_word) begin
              // Counter parks at the total; nothing more is accepted
              r_wcnt      <= c_WCNT_STOP;
              r_rdi_ready <= 1'b0;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= IDLE;
            end else if (w_last_in_buf) begin
              r_bcnt <= '0;
              r_buf  <= r_buf + c_BUF_W'(1);
`ifdef SB_PERBUF_RESEED_EN
              r_state     <= RESEED;
              r_reseed    <= 1'b1;
              r_rdi_ready <= 1'b0;
              r_seed      <= r_seed_base ^
                             {8'(r_buf) + 8'd1, {(SEED_W-8){1'b0}}};
`endif
            end else begin
              r_bcnt <= r_bcnt + c_BCNT_W'(1);
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  // Consumers own the shift enables only while IDLE; otherwise the
  // buffer currently being filled shifts on each accepted word.
  always_comb begin
    w_shift_en = '0;
    if (r_state == IDLE) begin
      w_shift_en = bs_en;
    end else begin
      for (int b = 0; b < NUM_BUF; b++) begin
        if (w_accept && (r_buf == c_BUF_W'(b))) w_shift_en[b] = 1'b1;
      end
    end
  end

  generate
    for (genvar b = 0; b < NUM_BUF; b++) begin : g_buf
      shift_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_shift_ram (
        .clk (clk),
        .en  (w_shift_en[b]),
        .di  (rdi_data),
        .so  (so[b*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

  assign busy      = r_busy;
  assign done      = r_done;
  assign byte_addr = r_byte_addr;
  assign seed      = r_seed;
  assign reseed    = r_reseed;
  assign rdi_ready = r_rdi_ready;

endmodule
`default_nettype wire

// File: tb/tb_sampler_buffer_mc.sv
`default_nettype none
// ============================================================================
// Module  : tb_sampler_buffer_mc
// Purpose : Directed self-checking bench for sampler_buffer_mc (default
//           parameters). Models a RAM_LAT=2 seed RAM, a PRNG that acks a
//           reseed two cycles after it rises and emits the accept index as
//           data, and checks buffer order, done timing and reset behaviour.
// Config  : SB_PERBUF_RESEED_EN changes the expected reseed count to 3.
// Rev     : 1.0  initial release
// ============================================================================
module tb_sampler_buffer_mc;

  localparam int NUM_BUF = 3;
  localparam int DEPTH   = 64;
  localparam int DW      = 128;
  localparam int SEED_W  = 256;
  localparam int TOTAL   = NUM_BUF * DEPTH;
`ifdef SB_PERBUF_RESEED_EN
  localparam int NRS = 3;
`else
  localparam int NRS = 1;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic                  busy, done, reseed, rdi_ready;
  logic [2:0]            byte_addr;
  logic [31:0]           byte_do = '0;
  logic [SEED_W-1:0]     seed;
  logic                  reseed_ack = 1'b0;
  logic [DW-1:0]         rdi_data;
  logic                  rdi_valid = 1'b0;
  logic [NUM_BUF-1:0]    bs_en = '0;
  logic [NUM_BUF*DW-1:0] so;

  sampler_buffer_mc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .byte_addr  (byte_addr),
    .byte_do    (byte_do),
    .seed       (seed),
    .reseed     (reseed),
    .reseed_ack (reseed_ack),
    .rdi_data   (rdi_data),
    .rdi_valid  (rdi_valid),
    .rdi_ready  (rdi_ready),
    .bs_en      (bs_en),
    .so         (so)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- environment models ----------------
  bit          pace = 0;      // 1: rdi_valid toggles every cycle
  bit          prng_on = 0;
  bit          prng_clr = 0;
  int          widx = 0;      // index of the next PRNG word
  bit          take = 0;      // accept happens at the coming edge
  int          rs_hi = 0;
  logic [2:0]  a_neg = '0;
  logic [31:0] st1 = '0;
  int          neg_cyc = 0, last_acc_neg = 0;
  int          acc_cnt = 0, done_cnt = 0, hs_cnt = 0, rise_cnt = 0;
  int          done_gap = -1;
  logic        done_busy = 1'b1;
  logic [7:0]  hs_top [32];
  logic [31:0] rise_lo [32];
  logic [31:0] rise_hi [32];
  logic        prev_reseed = 1'b0;

  assign rdi_data = DW'(widx);

  function automatic logic [31:0] ram_word(input logic [2:0] k);
    logic [31:0] w;
    w = 32'h1111_1111 * (32'(k) + 32'd1);
    return w;
  endfunction

  // Observation at the falling edge, where everything is settled
  always @(negedge clk) begin
    neg_cyc++;
    take = rst_n && rdi_valid && rdi_ready;
    if (take) begin
      acc_cnt++;
      last_acc_neg = neg_cyc;
    end
    if (rst_n && done) begin
      done_cnt++;
      done_gap  = neg_cyc - last_acc_neg;
      done_busy = busy;
    end
    if (reseed && !prev_reseed && rise_cnt < 32) begin
      rise_lo[rise_cnt] = seed[31:0];
      rise_hi[rise_cnt] = seed[255:224];
      rise_cnt++;
    end
    if (rst_n && reseed && reseed_ack) begin
      if (hs_cnt < 32) hs_top[hs_cnt] = seed[255:248];
      hs_cnt++;
    end
    prev_reseed = reseed;
    rs_hi = reseed ? rs_hi + 1 : 0;
    a_neg = byte_addr;
  end

  // Model-side drives, slightly after the rising edge
  always @(posedge clk) begin
    #2;
    byte_do = st1;            // two-stage RAM read pipeline
    st1     = ram_word(a_neg);
    if (prng_clr) widx = 0;
    else if (take) widx++;
    rdi_valid  = pace ? ~rdi_valid : prng_on;
    reseed_ack = (rs_hi == 2);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_prng();
    prng_clr = 1;
    tick();
    prng_clr = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int t;
    int d0;
    t  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && t < budget) begin
      tick();
      t++;
    end
    chk({tag, "_done_in_time"}, (t < budget), 1'b1);
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int t;
    t = 0;
    while (!rdi_ready && t < budget) begin
      tick();
      t++;
    end
    chk({tag, "_fill_reached"}, rdi_ready, 1'b1);
  endtask

  // Pop every buffer through its own enable and compare against accept order
  task automatic readout(input string tag);
    for (int b = 0; b < NUM_BUF; b++) begin
      bs_en = NUM_BUF'(1 << b);
      for (int i = 0; i < DEPTH; i++) begin
        chk($sformatf("%s_b%0d_w%0d", tag, b, i), so[b*DW +: DW], DW'(b*DEPTH + i));
        tick();
      end
      bs_en = '0;
    end
  endtask

  // Common post-run checks for a complete start..done sequence
  task automatic check_run(input string tag, input int acc0, input int done0,
                           input int hs0, input int rise0);
    chk({tag, "_accepts"}, acc_cnt - acc0, TOTAL);
    chk({tag, "_done_pulses"}, done_cnt - done0, 1);
    chk({tag, "_done_after_last"}, done_gap, 1);
    chk({tag, "_busy_at_done"}, done_busy, 1'b0);
    chk({tag, "_reseeds"}, hs_cnt - hs0, NRS);
    chk({tag, "_seed_lo"}, rise_lo[rise0], 32'h1111_1111);
    chk({tag, "_seed_hi"}, rise_hi[rise0], 32'h8888_8888);
    for (int h = 0; h < NRS; h++) begin
      chk($sformatf("%s_seed_top%0d", tag, h), hs_top[hs0 + h], 8'h88 ^ 8'(h));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int acc0, done0, hs0, rise0, t;

    // ---- reset state ----
    tick(3);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_reseed", reseed, 1'b0);
    chk("rst_rdi_ready", rdi_ready, 1'b0);
    chk("rst_byte_addr", byte_addr, 3'd0);
    chk("rst_seed", seed, '0);
    rst_n = 1;
    tick(2);

    // ---- run A: valid always, start and bs_en asserted during FILL ----
    prng_on = 1;
    clear_prng();
    acc0 = acc_cnt; done0 = done_cnt; hs0 = hs_cnt; rise0 = rise_cnt;
    pulse_start();
    chk("A_busy_after_start", busy, 1'b1);
    wait_ready("A", 200);
    bs_en = '1;
    tick(10);
    pulse_start();
    tick(30);
    bs_en = '0;
    wait_done("A", 2000);
    check_run("A", acc0, done0, hs0, rise0);
    tick(5);
    chk("A_no_restart_accepts", acc_cnt - acc0, TOTAL);
    chk("A_no_restart_busy", busy, 1'b0);
    readout("A");

    // ---- run B: backpressure, rdi_valid toggles ----
    pace = 1;
    clear_prng();
    acc0 = acc_cnt; done0 = done_cnt; hs0 = hs_cnt; rise0 = rise_cnt;
    pulse_start();
    wait_done("B", 3000);
    check_run("B", acc0, done0, hs0, rise0);
    readout("B");

    // ---- run C: reset in the middle of FILL, then a full restart ----
    pace = 0;
    clear_prng();
    pulse_start();
    t = 0;
    while (widx < 100 && t < 2000) begin
      tick();
      t++;
    end
    chk("C_reached_accept100", (widx >= 100), 1'b1);
    rst_n = 0;
    done0 = done_cnt;
    tick();
    chk("C_rst_busy", busy, 1'b0);
    chk("C_rst_rdi_ready", rdi_ready, 1'b0);
    chk("C_rst_byte_addr", byte_addr, 3'd0);
    rst_n = 1;
    tick(10);
    chk("C_no_done_after_rst", done_cnt - done0, 0);
    clear_prng();
    acc0 = acc_cnt; done0 = done_cnt; hs0 = hs_cnt; rise0 = rise_cnt;
    pulse_start();
    wait_done("C", 2000);
    check_run("C", acc0, done0, hs0, rise0);
    readout("C");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
